// File: rtl/svo_uart_term_rx_pkg.sv
// Shared types for the UART terminal receiver: FSM state encoding and byte type.
package svo_uart_term_rx_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Below this many clocks per bit the mid-bit sampling has no margin.
  localparam int DIV_MIN = 8;

endpackage

// File: rtl/svo_uart_term_rx_if.sv
// AXI-Stream-style byte channel from the UART receiver to the terminal core.
interface svo_uart_term_rx_if;
  import svo_uart_term_rx_pkg::*;

  logic  tvalid;
  logic  tready;
  byte_t tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/svo_sync_fifo.sv
// Single-clock FIFO, combinational head read; 1-cycle push-to-visible latency.
// A push while full is accepted only if a pop happens in the same cycle.
module svo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("svo_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok, push_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are unreachable until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/svo_uart_term_rx.sv
// 8N1 UART receiver feeding a byte FIFO; byte visible one cycle after its stop-bit sample.
// Consumer stalls via tready; a byte arriving while the FIFO is full is dropped with an overflow pulse.
module svo_uart_term_rx
  import svo_uart_term_rx_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx,
  svo_uart_term_rx_if.master out_axis,
  output logic               frame_err,
  output logic               overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

  if (DIV < DIV_MIN) begin : g_bad_div
    $error("svo_uart_term_rx: CLK_HZ/BAUD must be at least 8");
  end

  logic        sync1_q, rxs_q, rx_prev_q;
  logic [1:0]  warm_q;
  logic        start_det;

  // warm_q blocks start detection until rxs and rx_prev both reflect the real
  // line rather than reset values, so a line held low through reset is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
      warm_q    <= 2'd0;
    end else begin
      sync1_q   <= rx;
      rxs_q     <= sync1_q;
      rx_prev_q <= rxs_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign start_det = (warm_q == 2'd3) && rx_prev_q && !rxs_q;

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nbit_q, nbit_d;
  byte_t         sh_q, sh_d;
  logic          push_c, ferr_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nbit_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbit_q  <= nbit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    sh_d    = sh_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = ST_DATA;
            cnt_d   = CNT_FULL;
            nbit_d  = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = CNT_FULL;
          if (nbit_q == 3'd7) state_d = ST_STOP;
          else                nbit_d  = nbit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic           push, pop, fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;

  assign push = push_c && resetn;
  assign pop  = out_axis.tready && !fifo_empty;

  svo_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .push_dat_i (sh_q),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_o     (out_axis.tdata)
  );

  assign out_axis.tvalid = (fifo_count != '0);
  assign frame_err       = ferr_c && resetn;
  assign overflow        = push && fifo_full && !pop;

endmodule

// File: tb/tb_svo_uart_term_rx.sv
// Directed + random bench for svo_uart_term_rx at 10 clocks per bit, 16-entry FIFO.
`timescale 1ns/1ps
module tb_svo_uart_term_rx;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overflow;

  svo_uart_term_rx_if axis ();

  svo_uart_term_rx #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .out_axis  (axis),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  localparam int BIT = 10;
  localparam int DEPTH = 16;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] rxq [$];
  logic [7:0] expq [$];
  logic       stall = 1'b0;
  logic [7:0] stall_dat = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: records beats and pulses, and checks head stability under stall.
  always @(negedge clk) begin
    if (!resetn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        assert (axis.tvalid === 1'b1 && axis.tdata === stall_dat) else begin
          errors++;
          $error("FAIL stall_hold: got v=%0b d=0x%0h, want v=1 d=0x%0h",
                 axis.tvalid, axis.tdata, stall_dat);
        end
      end
      if (axis.tvalid && axis.tready) rxq.push_back(axis.tdata);
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      stall     = axis.tvalid && !axis.tready;
      stall_dat = axis.tdata;
    end
  end

  task automatic set_tready(input logic v);
    @(posedge clk);
    #1 axis.tready = v;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    if (stop_bit) rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rxq.size() < expq.size() && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rxq.size()) check(tag, rxq[i], expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int f0, o0;
    logic [7:0] b;

    axis.tready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_tdata", axis.tdata, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte and its latency from the falling edge.
    lat = 0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        @(negedge clk);
        while (!axis.tvalid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_latency_window", (lat >= 96 && lat <= 100), 1'b1);
    expq.push_back(8'h41);
    wait_drain();
    compare_rx("t1_byte");
    check("t1_frame_err", ferr_cnt, 0);
    check("t1_overflow", ovf_cnt, 0);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      expq.push_back(b);
      send_frame(b, 1'b1);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    wait_drain();
    compare_rx("rand_byte");

    // Short glitch rejected.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_no_beat", rxq.size(), 0);
    check("t2_no_ferr", ferr_cnt, 0);
    check("t2_no_ovf", ovf_cnt, 0);

    // Framing error, held-low break, then recovery.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("t3_one_ferr", ferr_cnt, f0 + 1);
    check("t3_no_beat", rxq.size(), 0);
    send_frame(8'h0F, 1'b1);
    expq.push_back(8'h0F);
    wait_drain();
    compare_rx("t3_recover");
    check("t3_ferr_total", ferr_cnt, f0 + 1);

    // Overflow on the 17th byte under full stall.
    o0 = ovf_cnt;
    set_tready(1'b0);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      repeat (3) @(negedge clk);
      if (i == DEPTH - 1) check("t4_no_ovf_at_16", ovf_cnt, o0);
      if (i < DEPTH) expq.push_back(8'(i));
    end
    check("t4_ovf_once", ovf_cnt, o0 + ((17 > DEPTH) ? 17 - DEPTH : 0));
    check("t4_held_head", axis.tdata, 8'h00);
    set_tready(1'b1);
    wait_drain();
    compare_rx("t4_drain");

    // Full FIFO, pop and push in the same cycle.
    o0 = ovf_cnt;
    set_tready(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1);
      expq.push_back(8'h20 + 8'(i));
    end
    repeat (5) @(negedge clk);
    check("t5_full_no_ovf", ovf_cnt, o0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        repeat (96) @(negedge clk);
        @(posedge clk);
        #1 axis.tready = 1'b1;
      end
    join
    expq.push_back(8'hA5);
    wait_drain();
    check("t5_no_ovf", ovf_cnt, o0);
    compare_rx("t5_order");

    // Reset mid-frame drops FIFO and partial byte without pulses.
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    set_tready(1'b0);
    send_frame(8'h77, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_pre_valid", axis.tvalid, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("t6_tvalid_after_rst", axis.tvalid, 1'b0);
    check("t6_tdata_after_rst", axis.tdata, 8'h00);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t6_no_ferr", ferr_cnt, f0);
    check("t6_no_ovf", ovf_cnt, o0);
    check("t6_still_empty", axis.tvalid, 1'b0);
    set_tready(1'b1);
    repeat (5) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    expq.push_back(8'h3C);
    wait_drain();
    compare_rx("t6_clean");
    check("t6_final_ferr", ferr_cnt, f0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
